// File: rtl/lsu_pkg.sv
// Shared defaults and FSM state encoding for the load/store unit.
package lsu_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 14;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t LD_WAIT  = 2'd1;
    localparam state_t ST_MERGE = 2'd2;

endpackage

// File: rtl/byte_merge.sv
// Replaces one byte of a 16-bit word; sel picks the high (1) or low (0) byte.
module byte_merge
    import lsu_pkg::*;
#(
    parameter int unsigned width = WIDTH
) (
    input  logic [width-1:0] old_word,
    input  logic [7:0]       new_byte,
    input  logic             sel,
    output logic [width-1:0] merged
);

    always_comb begin
        merged = old_word;
        if (sel) begin
            merged[15:8] = new_byte;
        end else begin
            merged[7:0] = new_byte;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word and byte accesses to a synchronous word-wide memory;
// byte stores are read-modify-write over two cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned width = WIDTH,
    parameter int unsigned aw    = AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic             req_byte,
    input  logic [aw:0]      req_addr,
    input  logic [width-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [width-1:0] rsp_rdata,
    output logic [aw-1:0]    mem_ad,
    output logic             mem_we,
    output logic [width-1:0] mem_di,
    input  logic [width-1:0] mem_dout
);

    state_t           state;
    logic [aw-1:0]    lat_ad;
    logic             lat_sel;
    logic             lat_byte;
    logic [7:0]       lat_data;
    logic             accept;
    logic [width-1:0] merged;
    logic [width-1:0] load_word;

    assign accept = req_valid && req_ready;

    byte_merge #(.width(width)) u_merge (
        .old_word (mem_dout),
        .new_byte (lat_data),
        .sel      (lat_sel),
        .merged   (merged)
    );

    always_comb begin
        req_ready = (state == IDLE);
        mem_ad    = req_addr[aw:1];
        mem_we    = 1'b0;
        mem_di    = req_wdata;
        case (state)
            IDLE:     mem_we = accept && req_we && !req_byte;
            LD_WAIT:  mem_ad = lat_ad;
            ST_MERGE: begin
                mem_ad = lat_ad;
                mem_we = 1'b1;
                mem_di = merged;
            end
            default: ;
        endcase
        // Reset must suppress a pending merge write in the same cycle it asserts.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_comb begin
        load_word = mem_dout;
        if (lat_byte) begin
            load_word = lat_sel ? {{(width-8){1'b0}}, mem_dout[15:8]}
                                : {{(width-8){1'b0}}, mem_dout[7:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_ad    <= '0;
            lat_sel   <= 1'b0;
            lat_byte  <= 1'b0;
            lat_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && (!req_we || req_byte)) begin
                        lat_ad   <= req_addr[aw:1];
                        lat_sel  <= req_addr[0];
                        lat_byte <= req_byte;
                        lat_data <= req_wdata[7:0];
                        state    <= req_we ? ST_MERGE : LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_word;
                    state     <= IDLE;
                end
                ST_MERGE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be:
- width, 16, data word width; byte operations are defined only for 16.
- aw, 14, word-address width of the data memory.

REQ-002 Ports SHALL be, in this order:
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, unit can accept a request this cycle.
- req_we, in, 1, 1 = store, 0 = load.
- req_byte, in, 1, 1 = byte access, 0 = word access.
- req_addr, in, aw+1, byte address; bit 0 selects the byte (0 = bits 7:0, 1 = bits 15:8).
- req_wdata, in, width, store data; a byte store uses bits 7:0 only.
- rsp_valid, out, 1, one-cycle pulse when load data is ready.
- rsp_rdata, out, width, load result.
- mem_ad, out, aw, memory word address.
- mem_we, out, 1, memory write enable.
- mem_di, out, width, memory write data.
- mem_dout, in, width, memory read data; valid one cycle after a read issue (we=0), and held while we=1.

REQ-003 A request SHALL be accepted in the cycle where req_valid and req_ready are both 1.

REQ-004 Load responses SHALL have no backpressure; the consumer always accepts rsp_valid.

Function
REQ-005 FSM states SHALL be IDLE, LD_WAIT and ST_MERGE. req_ready SHALL be 1 only in IDLE.

REQ-006 Word store accepted in cycle N:
- mem_we=1, mem_ad=req_addr[aw:1], mem_di=req_wdata, all combinational in cycle N.
- State stays IDLE; no response is issued.

REQ-007 Load accepted in cycle N:
- mem_we=0, mem_ad=req_addr[aw:1] in cycle N; state goes to LD_WAIT.
- In N+1, mem_dout is captured; state returns to IDLE.
- rsp_valid=1 in N+2 for exactly one cycle.
- A new request may be accepted in N+2.

REQ-008 Load data:
- Word load: rsp_rdata = the captured word.
- Byte load: rsp_rdata = the selected byte, zero-extended to 16 bits.

REQ-009 Byte store accepted in cycle N:
- Cycle N: read issue (mem_we=0), state goes to ST_MERGE.
- Cycle N+1: mem_we=1, mem_ad = latched address, mem_di = mem_dout with the selected byte replaced by the latched req_wdata[7:0]; state returns to IDLE.

REQ-010 Word accesses SHALL ignore req_addr[0]; no misalignment error is generated.

REQ-011 In LD_WAIT and ST_MERGE, mem_ad SHALL come from the address latched at acceptance, independent of req_addr.

REQ-012 mem_we SHALL be 1 only in the cycles named in REQ-006 and REQ-009.

REQ-013 In IDLE with no request, mem_we=0 and mem_ad=req_addr[aw:1]. This harmless read is permitted.

REQ-014 rsp_valid and rsp_rdata SHALL be registered outputs. rsp_rdata SHALL hold its last value when rsp_valid=0.

REQ-015 A request presented while req_ready=0 SHALL be ignored and SHALL have no memory side effect.

Reset
REQ-016 While rst=1, asynchronously:
- State = IDLE.
- rsp_valid=0, rsp_rdata=0.
- Latched address and data registers = 0.
- mem_we forced to 0.

REQ-017 Assertion of rst in LD_WAIT or ST_MERGE SHALL abort the operation:
- No response is issued.
- A pending byte-merge write is dropped; memory is unchanged.

REQ-018 In the first clock edge after rst deasserts, req_ready=1.

Structure
REQ-019 Package lsu_pkg SHALL hold the width and aw defaults and the FSM state typedef.

REQ-020 A combinational sub-module byte_merge (inputs: old word, byte, select; output: merged word) SHALL implement the merge. The memory itself is instantiated by the parent, not inside this unit.

Verification
REQ-021 Word store addr 0x0004, data 0xBEEF, then word load addr 0x0004 -> mem_we=1 for one cycle at ad 0x0002; rsp_valid two cycles after the load is accepted, rsp_rdata=0xBEEF.

REQ-022 Memory word 2 = 0x1234; byte store addr 0x0005, data 0x00AB -> mem_we in the second cycle with mem_di=0xAB34; a following word load returns 0xAB34.

REQ-023 Byte loads of addr 0x0004 and 0x0005 with word 0xAB34 -> rsp_rdata 0x0034 then 0x00AB.

REQ-024 req_valid held high during LD_WAIT/ST_MERGE with a conflicting store -> not accepted, memory unchanged, req_ready=0 in those cycles.

REQ-025 rst asserted in the ST_MERGE cycle of a byte store to word 0x0002 (value 0x1234) -> mem_we=0, word still 0x1234, rsp_valid=0, req_ready=1 after release.

REQ-026 Back-to-back accesses: word load, word store and byte load, each issued when req_ready=1 -> accepted cycles N, N+2, N+3; responses in N+2 and N+5; no dropped or duplicated rsp_valid.
